// File: rtl/demux2_16bit_stream_pkg.sv
// Shared constants for the 1-to-2 word demultiplexer: default word width
// and the channel index encoding used for in_sel.
package demux2_16bit_stream_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux2_16bit_stream_slot.sv
// One-entry output register slice with a saturating delivered-word counter.
// A load in the same cycle as an unload refills the slot, giving full throughput.
module demux_slot #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  logic unload;

  assign unload = full & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Clear wins over a same-cycle delivery; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (unload && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux2_16bit_stream.sv
// Registered 1-to-2 word demultiplexer: steers each accepted input word to one
// of two one-entry output slots selected by in_sel.
module demux2_16bit_stream
  import demux2_16bit_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  input  logic             clr_cnt
);

  logic in_fire;
  logic load0;
  logic load1;

  // Readiness looks only at the selected slot, so a stalled channel blocks
  // just the words aimed at it (head-of-line blocking is intended).
  assign in_ready = (in_sel == CH1) ? (~out1_valid | out1_ready)
                                    : (~out0_valid | out0_ready);

  assign in_fire = in_valid & in_ready;
  assign load0   = in_fire & (in_sel == CH0);
  assign load1   = in_fire & (in_sel == CH1);

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .out_ready (out0_ready),
    .clr_cnt   (clr_cnt),
    .data      (out0_data),
    .full      (out0_valid),
    .cnt       (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .out_ready (out1_ready),
    .clr_cnt   (clr_cnt),
    .data      (out1_data),
    .full      (out1_valid),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux2_16bit_stream.sv
// Randomised and directed bench for demux2_16bit_stream against a queue-based
// reference model; counters run at 4 bits so saturation is reachable.
module tb_demux2_16bit_stream;

  localparam int W    = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic          clr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of at most one word, plus a
  // count of deliveries since the last clear.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           mc0 = 0;
  int           mc1 = 0;

  demux2_16bit_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .clr_cnt    (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int satInc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic checkModelOutputs();
    checkOutput("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    checkOutput("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) checkOutput("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) checkOutput("out1_data", 32'(out1_data), 32'(q1[0]));
    checkOutput("cnt0", 32'(cnt0), 32'(mc0));
    checkOutput("cnt1", 32'(cnt1), 32'(mc1));
  endtask

  // Drives one cycle of inputs at the falling edge, checks the combinational
  // ready, lets the rising edge happen, then checks the registered outputs.
  task automatic applyStimulus(input logic v, input logic sel, input logic [W-1:0] d,
                               input logic r0, input logic r1, input logic clr);
    bit exp_rdy;
    bit pop0;
    bit pop1;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    clr_cnt    = clr;
    exp_rdy = sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    pop0 = (q0.size() != 0) && r0;
    pop1 = (q1.size() != 0) && r1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (v && exp_rdy) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    if (clr) begin
      mc0 = 0;
      mc1 = 0;
    end else begin
      if (pop0) mc0 = satInc(mc0);
      if (pop1) mc1 = satInc(mc1);
    end
    @(negedge clk);
    checkModelOutputs();
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    clr_cnt    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset then idle
    checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("rst_out0_data", 32'(out0_data), 32'd0);
    checkOutput("rst_out1_data", 32'(out1_data), 32'd0);
    checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("rst_cnt1", 32'(cnt1), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Single route to channel 1 with its consumer stalled
    applyStimulus(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    checkOutput("route_out1_valid", 32'(out1_valid), 32'd1);
    checkOutput("route_out1_data", 32'(out1_data), 32'hA5A5);
    checkOutput("route_out0_valid", 32'(out0_valid), 32'd0);
    in_valid = 1'b0;
    in_sel   = 1'b1;
    #1;
    checkOutput("route_ready_sel1", 32'(in_ready), 32'd0);
    in_sel = 1'b0;
    #1;
    checkOutput("route_ready_sel0", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

    // Stall hold on channel 0
    applyStimulus(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_data", 32'(out0_data), 32'h1234);
      checkOutput("stall_cnt0", 32'(cnt0), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_cnt0_after", 32'(cnt0), 32'd1);
    checkOutput("stall_drained", 32'(out0_valid), 32'd0);

    // Full throughput on channel 0
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("tput_data", 32'(out0_data), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("tput_cnt0", 32'(cnt0), 32'd8);

    // Saturation then clear racing a delivery on channel 1
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 16'(16'h100 + i), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_cnt1", 32'(cnt1), 32'd15);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_cnt1", 32'(cnt1), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), 1'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 40) == 0));

    // Reset mid-stream with both slots full
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_both_full", 32'(out0_valid & out1_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("mid_rst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("mid_rst_cnt1", 32'(cnt1), 32'd0);
    q0.delete();
    q1.delete();
    mc0 = 0;
    mc1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      checkOutput("post_rst_valid", 32'(out0_valid | out1_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
